bf_stdout_sched: RTL and testbench

- Output scheduler between the verifuck CPU's stdout port and the UART transmitter.
- Accepts one-cycle `stdout_en` byte strobes from the CPU and buffers them in a small FIFO.
- Drains the FIFO to the UART over a valid/ready handshake, optionally expanding LF into CR,LF.
- Back-pressures the CPU with `cpu_stall` before the buffer can overflow.

---
 rtl/bf_defs.sv | 18 +
 rtl/bf_byte_fifo.sv | 65 ++++++
 rtl/bf_stdout_sched.sv | 131 +++++++++++++
 tb/tb_bf_stdout_sched.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bf_defs.sv
// Shared constants and FSM encodings for the CPU stdout -> UART scheduler.
package bf_defs;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_CR   = 2'd2
    } sched_state_e;

    // True when a popped byte must be preceded by a CR on the wire.
    function automatic logic needs_cr(input logic [7:0] b, input logic crlf_en);
        return crlf_en && (b == ASCII_LF);
    endfunction

endpackage

// File: rtl/bf_byte_fifo.sv
// Byte FIFO with registered storage and a combinational head read.
// The caller guarantees push is only raised when space exists (or a pop
// happens in the same cycle) and pop only when the FIFO is not empty.
module bf_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [AW:0]   level_d;

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Next occupancy: +1 push-only, -1 pop-only, otherwise unchanged.
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == (AW+1)'(0));

endmodule

// File: rtl/bf_stdout_sched.sv
// Buffers CPU stdout strobes and drains them to the UART over valid/ready,
// optionally expanding LF into CR,LF. Stalls the CPU one slot before full.
module bf_stdout_sched
    import bf_defs::*;
#(
    parameter int DEPTH = 16,
    parameter bit CRLF  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               stdout,
    input  logic                     stdout_en,
    output logic                     cpu_stall,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int LW = $clog2(DEPTH) + 1;

    sched_state_e  state_q, state_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          overflow_q, overflow_d;

    logic          push_s;
    logic          pop_s;
    logic [7:0]    head_s;
    logic [LW-1:0] level_s;
    logic          full_s;
    logic          empty_s;

    bf_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (stdout),
        .pop       (pop_s),
        .head      (head_s),
        .level     (level_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // A strobe is accepted if there is room, or a slot frees up this cycle.
    assign push_s = stdout_en && (!full_s || pop_s);

    // Output FSM: pop one byte per load, hold it until the handshake.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        pop_s      = 1'b0;
        overflow_d = overflow_q | (stdout_en & ~push_s);
        case (state_q)
            S_IDLE: begin
                tx_valid_d = 1'b0;
                if (!empty_s) begin
                    pop_s      = 1'b1;
                    tx_valid_d = 1'b1;
                    if (needs_cr(head_s, CRLF)) begin
                        tx_data_d = ASCII_CR;
                        state_d   = S_CR;
                    end else begin
                        tx_data_d = head_s;
                        state_d   = S_SEND;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    if (!empty_s) begin
                        pop_s      = 1'b1;
                        tx_valid_d = 1'b1;
                        if (needs_cr(head_s, CRLF)) begin
                            tx_data_d = ASCII_CR;
                            state_d   = S_CR;
                        end else begin
                            tx_data_d = head_s;
                            state_d   = S_SEND;
                        end
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            S_CR: begin
                // The LF itself was popped when the CR was loaded.
                if (tx_ready) begin
                    tx_data_d = ASCII_LF;
                    state_d   = S_SEND;
                end else begin
                    state_d = S_CR;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // Scheduler state, output holding register and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign cpu_stall = (level_s >= LW'(DEPTH - 1));
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign level     = level_s;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_bf_stdout_sched.sv
// Directed self-checking bench for bf_stdout_sched (CRLF=1 and CRLF=0 instances).
module tb_bf_stdout_sched;

    logic       clk;
    logic       rst_n;
    logic [7:0] stdout;
    logic       stdout_en;
    logic       tx_ready;

    logic       cpu_stall, cpu_stall1;
    logic [7:0] tx_data, tx_data1;
    logic       tx_valid, tx_valid1;
    logic [4:0] level, level1;
    logic       overflow, overflow1;

    int total = 0;
    int bad   = 0;

    bf_stdout_sched #(.DEPTH(16), .CRLF(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .stdout(stdout), .stdout_en(stdout_en),
        .cpu_stall(cpu_stall), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .level(level), .overflow(overflow)
    );

    bf_stdout_sched #(.DEPTH(16), .CRLF(1'b0)) u_dut_nocr (
        .clk(clk), .rst_n(rst_n), .stdout(stdout), .stdout_en(stdout_en),
        .cpu_stall(cpu_stall1), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready), .level(level1), .overflow(overflow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one posedge and settle; all driving and sampling happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b);
        stdout    = b;
        stdout_en = 1'b1;
        tick();
        stdout_en = 1'b0;
    endtask

    task automatic do_reset();
        stdout_en = 1'b0;
        tx_ready  = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        stdout_en = 1'b0;
        stdout    = 8'h00;
        tx_ready  = 1'b0;
        rst_n     = 1'b0;
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", tx_valid); end
        total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", tx_data); end
        total++; if ({overflow, cpu_stall} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {overflow, cpu_stall}); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid got=%b exp=0", tx_valid); end
    endtask

    task automatic test_single_byte();
        tx_ready = 1'b1;
        strobe(8'h41);
        total++; if ({tx_valid, level} !== {1'b0, 5'd1}) begin bad++; $display("FAIL single_e got v=%b l=%0d exp v=0 l=1", tx_valid, level); end
        tick();
        total++; if ({tx_valid, tx_data} !== {1'b1, 8'h41}) begin bad++; $display("FAIL single_e1 got v=%b d=%h exp v=1 d=41", tx_valid, tx_data); end
        total++; if (level !== 5'd0) begin bad++; $display("FAIL single_e1_level got=%0d exp=0", level); end
        tick();
        total++; if ({tx_valid, level} !== {1'b0, 5'd0}) begin bad++; $display("FAIL single_e2 got v=%b l=%0d exp v=0 l=0", tx_valid, level); end
    endtask

    task automatic test_back_pressure();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'h41; exp_seq[1] = 8'h42; exp_seq[2] = 8'h43;
        tx_ready = 1'b0;
        strobe(8'h41);
        strobe(8'h42);
        strobe(8'h43);
        tick();
        total++; if ({tx_valid, tx_data, level} !== {1'b1, 8'h41, 5'd2}) begin bad++; $display("FAIL bp_hold got v=%b d=%h l=%0d exp v=1 d=41 l=2", tx_valid, tx_data, level); end
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if ({tx_valid, tx_data} !== {1'b1, exp_seq[i]}) begin bad++; $display("FAIL bp_drain%0d got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, exp_seq[i]); end
            tick();
        end
        total++; if ({tx_valid, level} !== {1'b0, 5'd0}) begin bad++; $display("FAIL bp_end got v=%b l=%0d exp v=0 l=0", tx_valid, level); end
    endtask

    task automatic test_crlf();
        tx_ready = 1'b1;
        strobe(8'h48);
        strobe(8'h0A);
        total++; if ({tx_valid, tx_data, tx_valid1, tx_data1} !== {1'b1, 8'h48, 1'b1, 8'h48}) begin bad++; $display("FAIL crlf_c0 got %b %h / %b %h exp 1 48 / 1 48", tx_valid, tx_data, tx_valid1, tx_data1); end
        tick();
        total++; if ({tx_valid, tx_data, tx_valid1, tx_data1} !== {1'b1, 8'h0D, 1'b1, 8'h0A}) begin bad++; $display("FAIL crlf_c1 got %b %h / %b %h exp 1 0d / 1 0a", tx_valid, tx_data, tx_valid1, tx_data1); end
        tick();
        total++; if ({tx_valid, tx_data, tx_valid1} !== {1'b1, 8'h0A, 1'b0}) begin bad++; $display("FAIL crlf_c2 got %b %h / %b exp 1 0a / 0", tx_valid, tx_data, tx_valid1); end
        tick();
        total++; if ({tx_valid, level} !== {1'b0, 5'd0}) begin bad++; $display("FAIL crlf_c3 got v=%b l=%0d exp v=0 l=0", tx_valid, level); end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            b = 8'h60 + 8'(i);
            strobe(b);
            if (i == 14) begin
                total++; if ({level, cpu_stall} !== {5'd14, 1'b0}) begin bad++; $display("FAIL fill_15 got l=%0d s=%b exp l=14 s=0", level, cpu_stall); end
            end else if (i == 15) begin
                total++; if ({level, cpu_stall} !== {5'd15, 1'b1}) begin bad++; $display("FAIL fill_16 got l=%0d s=%b exp l=15 s=1", level, cpu_stall); end
            end
        end
        total++; if ({level, overflow, tx_data} !== {5'd16, 1'b0, 8'h60}) begin bad++; $display("FAIL fill_17 got l=%0d o=%b d=%h exp l=16 o=0 d=60", level, overflow, tx_data); end
        strobe(8'h7F);
        total++; if ({level, overflow} !== {5'd16, 1'b1}) begin bad++; $display("FAIL fill_drop got l=%0d o=%b exp l=16 o=1", level, overflow); end
        total++; if ({overflow1, cpu_stall1} !== 2'b11) begin bad++; $display("FAIL fill_drop_nocr got %b exp 11", {overflow1, cpu_stall1}); end
        tx_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            b = 8'h60 + 8'(i);
            total++; if ({tx_valid, tx_data} !== {1'b1, b}) begin bad++; $display("FAIL fill_drain%0d got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, b); end
            tick();
        end
        total++; if ({tx_valid, level, overflow} !== {1'b0, 5'd0, 1'b1}) begin bad++; $display("FAIL fill_end got v=%b l=%0d o=%b exp v=0 l=0 o=1", tx_valid, level, overflow); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            b = 8'h20 + 8'(i);
            strobe(b);
        end
        total++; if ({level, overflow} !== {5'd16, 1'b0}) begin bad++; $display("FAIL pp_full got l=%0d o=%b exp l=16 o=0", level, overflow); end
        tx_ready = 1'b1;
        strobe(8'h5A);
        total++; if ({level, overflow, tx_data} !== {5'd16, 1'b0, 8'h21}) begin bad++; $display("FAIL pp_both got l=%0d o=%b d=%h exp l=16 o=0 d=21", level, overflow, tx_data); end
        for (int i = 0; i < 17; i++) begin
            b = (i < 16) ? (8'h21 + 8'(i)) : 8'h5A;
            total++; if ({tx_valid, tx_data} !== {1'b1, b}) begin bad++; $display("FAIL pp_drain%0d got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, b); end
            tick();
        end
        total++; if ({tx_valid, level} !== {1'b0, 5'd0}) begin bad++; $display("FAIL pp_end got v=%b l=%0d exp v=0 l=0", tx_valid, level); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            b = 8'h31 + 8'(i);
            strobe(b);
        end
        total++; if ({tx_valid, tx_data, level} !== {1'b1, 8'h31, 5'd5}) begin bad++; $display("FAIL rm_pre got v=%b d=%h l=%0d exp v=1 d=31 l=5", tx_valid, tx_data, level); end
        rst_n = 1'b0;
        #1;
        total++; if ({tx_valid, level, level1} !== {1'b0, 5'd0, 5'd0}) begin bad++; $display("FAIL rm_async got v=%b l=%0d l1=%0d exp v=0 l=0 l1=0", tx_valid, level, level1); end
        tick();
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if ({tx_valid, tx_valid1} !== 2'b00) begin bad++; $display("FAIL rm_stale%0d got %b exp 00", i, {tx_valid, tx_valid1}); end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_pressure();
        test_crlf();
        test_fill_overflow();
        test_push_pop_full();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
